// File: rtl/accelerator_pkg.sv
// Shared types and helpers for the vector load/store unit.
package accelerator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE,
    END
  } vlsu_state_t;

  localparam logic [1:0] SEW8  = 2'd0;
  localparam logic [1:0] SEW16 = 2'd1;
  localparam logic [1:0] SEW32 = 2'd2;

  // Elements packed into one 32-bit register word.
  function automatic logic [2:0] elems_per_word(input logic [1:0] sew);
    case (sew)
      SEW8:    elems_per_word = 3'd4;
      SEW16:   elems_per_word = 3'd2;
      default: elems_per_word = 3'd1;
    endcase
  endfunction

  // Byte offset of an element's lane within its register word.
  function automatic logic [1:0] lane_byte_off(input logic [1:0] sew, input logic [4:0] elem);
    case (sew)
      SEW8:    lane_byte_off = elem[1:0];
      SEW16:   lane_byte_off = {elem[0], 1'b0};
      default: lane_byte_off = 2'b00;
    endcase
  endfunction

  // Expand per-byte enables into a 32-bit bit mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    be_to_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/vlsu_lane_align.sv
// Byte-lane steering for single-element (strided) memory accesses.
module vlsu_lane_align
  import accelerator_pkg::*;
(
  input  logic [1:0]  sew_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] elem_wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_elem_o
);

  logic [31:0] rshift;

  // Byte enables, replicated write data and zero-extended read element.
  always_comb begin
    rshift = rdata_i >> {addr_lo_i, 3'b000};
    case (sew_i)
      SEW8: begin
        be_o         = 4'b0001 << addr_lo_i;
        wdata_o      = {4{elem_wdata_i[7:0]}};
        rdata_elem_o = {24'h0, rshift[7:0]};
      end
      SEW16: begin
        be_o         = 4'b0011 << addr_lo_i;
        wdata_o      = {2{elem_wdata_i[15:0]}};
        rdata_elem_o = {16'h0, rshift[15:0]};
      end
      default: begin
        be_o         = 4'hF;
        wdata_o      = elem_wdata_i;
        rdata_elem_o = rshift;
      end
    endcase
  end

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: unit-stride and strided SEW 8/16/32 accesses over
// a single-outstanding OBI-style port, one register word per ready pulse.
module vector_lsu
  import accelerator_pkg::*;
#(
  parameter int unsigned VLEN_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vlsu_en_i,
  input  logic        vlsu_load_i,
  input  logic        vlsu_store_i,
  input  logic        vlsu_strided_i,
  input  logic [31:0] base_addr_i,
  input  logic [31:0] stride_i,
  input  logic [4:0]  vl_i,
  input  logic [1:0]  vsew_i,
  input  logic [4:0]  vs3_addr_i,
  output logic [4:0]  vreg_rd_addr_o,
  input  logic [31:0] vreg_rd_data_i,
  output logic [31:0] load_data_o,
  output logic        vlsu_ready_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);

  vlsu_state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, stride_q, stride_d, buf_q, buf_d;
  logic [4:0]  vl_q, vl_d, vs3_q, vs3_d, elem_q, elem_d, word_q, word_d;
  logic [1:0]  sew_q, sew_d;
  logic        store_q, store_d, strided_q, strided_d, abort_q, abort_d;

  logic [2:0]  epw;
  logic [1:0]  byte_off, nxt_off;
  logic [4:0]  rem_elems, elem_step, elem_nx;
  logic [6:0]  total_bytes, rem_bytes;
  logic [3:0]  unit_be, la_be;
  logic [31:0] elem_wsrc, la_wdata, la_rdata;
  logic        word_full;

  vlsu_lane_align u_lane_align (
    .sew_i        (sew_q),
    .addr_lo_i    (addr_q[1:0]),
    .elem_wdata_i (elem_wsrc),
    .rdata_i      (data_rdata_i),
    .be_o         (la_be),
    .wdata_o      (la_wdata),
    .rdata_elem_o (la_rdata)
  );

  // Per-access datapath: element progress, word completion, unit-stride tail mask.
  always_comb begin
    epw       = elems_per_word(sew_q);
    byte_off  = lane_byte_off(sew_q, elem_q);
    rem_elems = vl_q - elem_q;
    if (strided_q)                      elem_step = 5'd1;
    else if (rem_elems < {2'b00, epw})  elem_step = rem_elems;
    else                                elem_step = {2'b00, epw};
    elem_nx   = elem_q + elem_step;
    nxt_off   = lane_byte_off(sew_q, elem_nx);
    word_full = !strided_q || (elem_nx == vl_q) || (nxt_off == 2'd0);
    total_bytes = {2'b00, vl_q} << sew_q;
    rem_bytes   = total_bytes - {word_q, 2'b00};
    unit_be     = (rem_bytes >= 7'd4) ? 4'hF : ((4'b0001 << rem_bytes[1:0]) - 4'd1);
    elem_wsrc   = vreg_rd_data_i >> {byte_off, 3'b000};
  end

  // Interface outputs; the memory side is only driven while requesting.
  always_comb begin
    data_req_o     = (state_q == REQ) && vlsu_en_i;
    data_addr_o    = '0;
    data_we_o      = 1'b0;
    data_be_o      = '0;
    data_wdata_o   = '0;
    if (state_q == REQ) begin
      data_addr_o = addr_q;
      data_we_o   = store_q;
      data_be_o   = strided_q ? la_be : unit_be;
      if (store_q) data_wdata_o = strided_q ? la_wdata : vreg_rd_data_i;
    end
    vreg_rd_addr_o = vs3_q + word_q;
    load_data_o    = (state_q == DONE) ? buf_q : '0;
    vlsu_ready_o   = !vlsu_en_i || (state_q == DONE) || (state_q == END) ||
                     ((state_q == IDLE) && (vlsu_load_i || vlsu_store_i) && (vl_i == 5'd0));
  end

  // Next-state and operand capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    stride_d  = stride_q;
    buf_d     = buf_q;
    vl_d      = vl_q;
    vs3_d     = vs3_q;
    elem_d    = elem_q;
    word_d    = word_q;
    sew_d     = sew_q;
    store_d   = store_q;
    strided_d = strided_q;
    abort_d   = abort_q;
    case (state_q)
      IDLE: begin
        if (vlsu_en_i && (vlsu_load_i || vlsu_store_i)) begin
          stride_d  = stride_i;
          vl_d      = vl_i;
          sew_d     = (vsew_i == 2'd3) ? SEW32 : vsew_i;
          store_d   = !vlsu_load_i;
          strided_d = vlsu_strided_i;
          vs3_d     = vs3_addr_i;
          addr_d    = vlsu_strided_i ? base_addr_i : {base_addr_i[31:2], 2'b00};
          buf_d     = '0;
          elem_d    = '0;
          word_d    = '0;
          abort_d   = 1'b0;
          state_d   = (vl_i == 5'd0) ? END : REQ;
        end
      end
      REQ: begin
        if (!vlsu_en_i)      state_d = IDLE;
        else if (data_gnt_i) state_d = WAIT_R;
      end
      WAIT_R: begin
        // A granted access must still retire; en dropping only marks it discarded.
        if (!vlsu_en_i) abort_d = 1'b1;
        if (data_rvalid_i) begin
          if (!vlsu_en_i || abort_q) begin
            state_d = IDLE;
          end else begin
            if (!store_q) buf_d = strided_q ? (buf_q | (la_rdata << {byte_off, 3'b000}))
                                            : (data_rdata_i & be_to_mask(unit_be));
            elem_d  = elem_nx;
            addr_d  = addr_q + (strided_q ? stride_q : 32'(VLEN_BYTES));
            state_d = word_full ? DONE : REQ;
          end
        end
      end
      DONE: begin
        buf_d  = '0;
        word_d = word_q + 5'd1;
        if (!vlsu_en_i)          state_d = IDLE;
        else if (elem_q < vl_q)  state_d = REQ;
        else                     state_d = END;
      end
      END: begin
        if (!vlsu_en_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      stride_q  <= '0;
      buf_q     <= '0;
      vl_q      <= '0;
      vs3_q     <= '0;
      elem_q    <= '0;
      word_q    <= '0;
      sew_q     <= SEW8;
      store_q   <= 1'b0;
      strided_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      stride_q  <= stride_d;
      buf_q     <= buf_d;
      vl_q      <= vl_d;
      vs3_q     <= vs3_d;
      elem_q    <= elem_d;
      word_q    <= word_d;
      sew_q     <= sew_d;
      store_q   <= store_d;
      strided_q <= strided_d;
      abort_q   <= abort_d;
    end
  end

endmodule
